// File: rtl/obstacle_field_gen.sv
// Multi-lane scrolling obstacle field with LFSR-driven spawning, MIN_GAP spacing and player collision.
// Optional pass counter enabled by defining OBST_PASS_COUNT_EN; otherwise pass_cnt is tied to zero.
module obstacle_field_gen #(
    parameter int          WIDTH      = 16,
    parameter int          LANES      = 2,
    parameter int          MIN_GAP    = 3,
    parameter int          PLAYER_COL = 12,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [7:0]               density,
    input  logic [1:0]               player_lane,
    output logic [LANES*WIDTH-1:0]   obstacles,
    output logic                     hit,
    output logic [15:0]              pass_cnt
);

    localparam logic [3:0]  GAP_MAX   = 4'(MIN_GAP);
    localparam logic [2:0]  LANES_W   = 3'(LANES);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [15:0]            lfsr_q, lfsr_d;
    logic [3:0]             gap_cnt_q, gap_cnt_d;
    logic [LANES*WIDTH-1:0] obstacles_q, obstacles_d;
    logic                   spawn_ok;
    logic [1:0]             spawn_lane;

    always_comb begin
        // Galois right-shift LFSR runs every cycle so spawn timing is not tied to the tick rate
        lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        spawn_ok    = (gap_cnt_q >= GAP_MAX) && (lfsr_q[7:0] < density);
        spawn_lane  = ({1'b0, lfsr_q[9:8]} >= LANES_W) ? 2'd0 : lfsr_q[9:8];
        obstacles_d = obstacles_q;
        gap_cnt_d   = gap_cnt_q;
        if (en) begin
            for (int l = 0; l < LANES; l++) begin
                obstacles_d[l*WIDTH +: WIDTH] =
                    {obstacles_q[l*WIDTH +: WIDTH-1], spawn_ok && (spawn_lane == 2'(l))};
            end
            if (spawn_ok) begin
                gap_cnt_d = 4'd0;
            end else if (gap_cnt_q < GAP_MAX) begin
                gap_cnt_d = gap_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q      <= SEED;
            gap_cnt_q   <= GAP_MAX;
            obstacles_q <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            gap_cnt_q   <= gap_cnt_d;
            obstacles_q <= obstacles_d;
        end
    end

    // Lanes beyond LANES have no cells, so the player there can never be hit
    always_comb begin
        hit = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (player_lane == 2'(l)) begin
                hit = obstacles_q[l*WIDTH + PLAYER_COL];
            end
        end
    end

    assign obstacles = obstacles_q;

`ifdef OBST_PASS_COUNT_EN
    logic [15:0] pass_cnt_q, pass_cnt_d;
    logic        exit_any;

    always_comb begin
        exit_any = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            exit_any = exit_any | obstacles_q[l*WIDTH + WIDTH - 1];
        end
        pass_cnt_d = pass_cnt_q;
        if (en && exit_any && (pass_cnt_q != 16'hFFFF)) begin
            pass_cnt_d = pass_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt_q <= 16'h0000;
        end else begin
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
`else
    assign pass_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_obstacle_field_gen.sv
// Randomized bench for obstacle_field_gen: reference model keeps a list of obstacles
// (lane, column) and the tick of the last spawn, and is compared every cycle.
module tb_obstacle_field_gen;

  localparam int WIDTH      = 16;
  localparam int LANES      = 3;
  localparam int MIN_GAP    = 3;
  localparam int PLAYER_COL = 12;
  localparam logic [15:0] SEED = 16'hACE1;

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   en = 1'b0;
  logic [7:0]             density = 8'd0;
  logic [1:0]             player_lane = 2'd0;
  logic [LANES*WIDTH-1:0] obstacles;
  logic                   hit;
  logic [15:0]            pass_cnt;

  obstacle_field_gen #(
    .WIDTH(WIDTH), .LANES(LANES), .MIN_GAP(MIN_GAP), .PLAYER_COL(PLAYER_COL), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .density(density), .player_lane(player_lane),
    .obstacles(obstacles), .hit(hit), .pass_cnt(pass_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model
  typedef struct { int lane; int col; } obs_t;
  obs_t        field_q[$];
  logic [15:0] m_lfsr;
  int          m_tick;
  int          m_last_spawn;
  int          m_pass;
  int          m_spawns;

  function automatic void model_reset();
    field_q.delete();
    m_lfsr       = SEED;
    m_tick       = 0;
    m_last_spawn = -1000;
    m_pass       = 0;
  endfunction

  function automatic void model_edge(input logic en_v, input logic [7:0] dens);
    obs_t nf[$];
    bit   at_exit;
    int   lane;
    bit   spawn;
    if (en_v) begin
      spawn   = ((m_tick - m_last_spawn) >= MIN_GAP + 1) && (int'(m_lfsr & 16'hFF) < int'(dens));
      lane    = int'((m_lfsr >> 8) & 16'h3);
      if (lane >= LANES) lane = 0;
      at_exit = 1'b0;
      foreach (field_q[i]) begin
        if (field_q[i].col == WIDTH - 1) at_exit = 1'b1;
        else nf.push_back('{lane: field_q[i].lane, col: field_q[i].col + 1});
      end
      if (at_exit && m_pass < 65535) m_pass++;
      if (spawn) begin
        nf.push_back('{lane: lane, col: 0});
        m_last_spawn = m_tick;
        m_spawns++;
      end
      field_q = nf;
      m_tick++;
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [LANES*WIDTH-1:0] model_vec();
    logic [LANES*WIDTH-1:0] v = '0;
    foreach (field_q[i]) v[field_q[i].lane*WIDTH + field_q[i].col] = 1'b1;
    return v;
  endfunction

  function automatic logic model_hit(input logic [1:0] pl);
    foreach (field_q[i])
      if (field_q[i].lane == int'(pl) && field_q[i].col == PLAYER_COL) return 1'b1;
    return 1'b0;
  endfunction

  // scoreboard: expected field for this cycle is queued then popped against the DUT
  logic [LANES*WIDTH-1:0] exp_q[$];

  task automatic compare_all();
    logic [LANES*WIDTH-1:0] e;
    logic [15:0]            exp_pass;
    int                     cnt;
    bit                     one_per_col;
    exp_q.push_back(model_vec());
    e = exp_q.pop_front();
    check("obstacles", 64'(obstacles), 64'(e));
    check("hit", 64'(hit), 64'(model_hit(player_lane)));
`ifdef OBST_PASS_COUNT_EN
    exp_pass = 16'(m_pass);
`else
    exp_pass = 16'h0000;
`endif
    check("pass_cnt", 64'(pass_cnt), 64'(exp_pass));
    one_per_col = 1'b1;
    for (int c = 0; c < WIDTH; c++) begin
      cnt = 0;
      for (int l = 0; l < LANES; l++) cnt += int'(obstacles[l*WIDTH + c]);
      if (cnt > 1) one_per_col = 1'b0;
    end
    check("one_per_col", 64'(one_per_col), 64'd1);
  endtask

  // driver tasks
  task automatic drive_cycle(input logic en_v, input logic [7:0] dens, input logic [1:0] pl);
    en          = en_v;
    density     = dens;
    player_lane = pl;
    @(posedge clk);
    if (!rst) model_edge(en_v, dens);
    #1;
    compare_all();
  endtask

  task automatic random_cycles(input int n, input int dens_lo, input int dens_hi);
    for (int i = 0; i < n; i++)
      drive_cycle($urandom_range(0, 3) != 0, 8'($urandom_range(dens_lo, dens_hi)),
                  2'($urandom_range(0, 3)));
  endtask

  logic [LANES*WIDTH-1:0] snap;

  initial begin
    m_spawns = 0;
    model_reset();
    // reset held with en and density active
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'd255, 2'd1);
    rst = 1'b0;

    // density 0: field stays empty
    for (int i = 0; i < 100; i++) drive_cycle(1'b1, 8'd0, 2'($urandom_range(0, 3)));

    // density 255: back-to-back spawns limited only by MIN_GAP
    for (int i = 0; i < 64; i++) drive_cycle(1'b1, 8'd255, 2'($urandom_range(0, 3)));

    // mixed random traffic
    random_cycles(300, 0, 255);

    // en held low: field frozen
    snap = obstacles;
    for (int i = 0; i < 50; i++) begin
      drive_cycle(1'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      check("en_hold", 64'(obstacles), 64'(snap));
    end

    random_cycles(100, 128, 255);

    // async reset mid-cycle clears the field immediately
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_obstacles", 64'(obstacles), 64'd0);
    check("async_rst_pass_cnt", 64'(pass_cnt), 64'd0);
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 8'd255, 2'd0);
    rst = 1'b0;

    // sparse spawns so obstacles leave isolated, then more random traffic
    random_cycles(80, 0, 40);
    random_cycles(150, 0, 255);
    for (int i = 0; i < WIDTH + 5; i++) drive_cycle(1'b1, 8'd0, 2'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
